// File: rtl/permutator_pipe.sv
// Elastic lane permutator: one registered butterfly stage per cfg bit (LSB first),
// supporting XOR (butterfly) and rotate lane reordering with full backpressure.
module permutator_pipe #(
  parameter  int LANES = 8,
  parameter  int DW    = 16,
  localparam int L2    = $clog2(LANES)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [LANES*DW-1:0] t_dat,
  input  logic [L2-1:0]       t_cfg,
  input  logic                t_mode,
  input  logic                t_valid,
  output logic                t_ready,
  output logic [LANES*DW-1:0] i_dat,
  output logic [L2-1:0]       i_cfg,
  output logic                i_mode,
  output logic                i_valid,
  input  logic                i_ready,
  output logic [15:0]         beat_cnt
);

  logic [LANES*DW-1:0] dat_q [L2];
  logic [L2-1:0]       cfg_q [L2];
  logic [L2-1:0]       mode_q;
  logic [L2-1:0]       v_q;
  logic [L2:0]         rdy;

  // Ready ripples back from the consumer; a stage can load if empty or draining.
  always_comb begin
    rdy[L2] = i_ready;
    for (int s = L2 - 1; s >= 0; s--) begin
      rdy[s] = !v_q[s] || rdy[s+1];
    end
  end

  assign t_ready = rdy[0];

  for (genvar s = 0; s < L2; s++) begin : g_stage
    logic [LANES*DW-1:0] in_dat;
    logic [LANES*DW-1:0] perm;
    logic [LANES*DW-1:0] dat_r;
    logic [L2-1:0]       in_cfg;
    logic [L2-1:0]       cfg_r;
    logic                in_mode;
    logic                in_valid;
    logic                mode_r;
    logic                v_r;

    if (s == 0) begin : g_first
      assign in_dat   = t_dat;
      assign in_cfg   = t_cfg;
      assign in_mode  = t_mode;
      assign in_valid = t_valid;
    end else begin : g_next
      assign in_dat   = dat_q[s-1];
      assign in_cfg   = cfg_q[s-1];
      assign in_mode  = mode_q[s-1];
      assign in_valid = v_q[s-1];
    end

    // Stage s moves lanes by distance 2^s when cfg bit s is set.
    always_comb begin
      perm = in_dat;
      if (in_cfg[s]) begin
        for (int j = 0; j < LANES; j++) begin
          if (in_mode) begin
            perm[j*DW +: DW] = in_dat[((j + (1 << s)) % LANES)*DW +: DW];
          end else begin
            perm[j*DW +: DW] = in_dat[(j ^ (1 << s))*DW +: DW];
          end
        end
      end
    end

    // Payload only loads with a valid beat so bubbles leave the data untouched.
    always_ff @(posedge clk) begin
      if (rst) begin
        v_r    <= 1'b0;
        dat_r  <= '0;
        cfg_r  <= '0;
        mode_r <= 1'b0;
      end else if (rdy[s]) begin
        v_r <= in_valid;
        if (in_valid) begin
          dat_r  <= perm;
          cfg_r  <= in_cfg;
          mode_r <= in_mode;
        end
      end
    end

    assign dat_q[s]  = dat_r;
    assign cfg_q[s]  = cfg_r;
    assign mode_q[s] = mode_r;
    assign v_q[s]    = v_r;
  end

  assign i_dat   = dat_q[L2-1];
  assign i_cfg   = cfg_q[L2-1];
  assign i_mode  = mode_q[L2-1];
  assign i_valid = v_q[L2-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt <= '0;
    end else if (i_valid && i_ready) begin
      beat_cnt <= beat_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_permutator_pipe.sv
// Scoreboard bench for permutator_pipe: expected beats are queued on input transfer
// and compared on output transfer, plus directed latency/backpressure/reset checks.
module tb_permutator_pipe;

  localparam int LANES = 8;
  localparam int DW    = 16;
  localparam int L2    = 3;
  localparam int W     = LANES*DW;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  t_dat;
  logic [L2-1:0] t_cfg;
  logic          t_mode;
  logic          t_valid;
  logic          t_ready;
  logic [W-1:0]  i_dat;
  logic [L2-1:0] i_cfg;
  logic          i_mode;
  logic          i_valid;
  logic          i_ready;
  logic [15:0]   beat_cnt;

  typedef struct packed {
    logic [W-1:0]  dat;
    logic [L2-1:0] cfg;
    logic          mode;
  } beat_t;

  beat_t sb[$];
  int checks = 0;
  int failures = 0;
  int delivered = 0;

  permutator_pipe #(.LANES(LANES), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .t_dat(t_dat), .t_cfg(t_cfg), .t_mode(t_mode), .t_valid(t_valid), .t_ready(t_ready),
    .i_dat(i_dat), .i_cfg(i_cfg), .i_mode(i_mode), .i_valid(i_valid), .i_ready(i_ready),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic [L2-1:0] c,
                                         input logic m);
    logic [W-1:0] r;
    int src;
    r = '0;
    for (int j = 0; j < LANES; j++) begin
      src = m ? (j + int'(c)) % LANES : (j ^ int'(c));
      r[j*DW +: DW] = d[src*DW +: DW];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] ramp();
    logic [W-1:0] r;
    for (int k = 0; k < LANES; k++) r[k*DW +: DW] = 16'(k);
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic [L2-1:0] cfg, input logic mode, input logic valid);
    t_dat   = ramp();
    t_cfg   = cfg;
    t_mode  = mode;
    t_valid = valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string tag);
    int budget;
    budget = 50;
    while ((sb.size() != 0 || i_valid) && budget > 0) begin
      step();
      budget--;
    end
    checkOutput(tag, {sb.size() != 0, i_valid}, 0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(0, 0, 0);
    step();
    step();
    rst = 1'b0;
  endtask

  // Inputs change just after posedge, so the negedge sees the values the next edge uses.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      sb.delete();
      delivered = 0;
    end else begin
      if (i_valid && i_ready) begin
        checkOutput("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("sb_dat", i_dat, e.dat);
          checkOutput("sb_cfg_mode", {i_cfg, i_mode}, {e.cfg, e.mode});
        end
        delivered++;
      end
      if (t_valid && t_ready) begin
        e.dat  = model(t_dat, t_cfg, t_mode);
        e.cfg  = t_cfg;
        e.mode = t_mode;
        sb.push_back(e);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int acc;
    int ghost;
    logic [W-1:0] hold;

    i_ready = 1'b1;
    doReset();
    checkOutput("rst_i_valid", i_valid, 0);
    checkOutput("rst_i_dat", i_dat, 0);
    checkOutput("rst_i_cfg", i_cfg, 0);
    checkOutput("rst_i_mode", i_mode, 0);
    checkOutput("rst_beat_cnt", beat_cnt, 0);
    checkOutput("rst_t_ready", t_ready, 1);

    applyStimulus(0, 0, 1);
    step();
    applyStimulus(0, 0, 0);
    checkOutput("id_lat_e0", i_valid, 0);
    step();
    checkOutput("id_lat_e1", i_valid, 0);
    step();
    checkOutput("id_lat_e2", i_valid, 1);
    checkOutput("id_dat", i_dat, 128'h0007_0006_0005_0004_0003_0002_0001_0000);
    drain("id_drain");

    applyStimulus(3, 0, 1);
    step();
    applyStimulus(0, 0, 0);
    step();
    step();
    checkOutput("xor_valid", i_valid, 1);
    checkOutput("xor_dat", i_dat, 128'h0004_0005_0006_0007_0000_0001_0002_0003);
    checkOutput("xor_cfg", i_cfg, 3);
    checkOutput("xor_mode", i_mode, 0);
    drain("xor_drain");
    checkOutput("xor_beat_cnt", beat_cnt, 2);

    doReset();
    applyStimulus(3, 1, 1);
    step();
    applyStimulus(0, 0, 0);
    step();
    step();
    checkOutput("rot_valid", i_valid, 1);
    checkOutput("rot_dat", i_dat, 128'h0002_0001_0000_0007_0006_0005_0004_0003);
    checkOutput("rot_cfg_mode", {i_cfg, i_mode}, {3'd3, 1'b1});
    drain("rot_drain");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(L2'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1);
      checkOutput("b2b_t_ready", t_ready, 1);
      step();
    end
    applyStimulus(0, 0, 0);
    drain("b2b_drain");
    checkOutput("b2b_beat_cnt", beat_cnt, 21);

    i_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(L2'(i + 1), 1'(i % 2), 1);
      if (t_ready) acc++;
      step();
    end
    checkOutput("bp_accepted", acc, 3);
    checkOutput("bp_t_ready", t_ready, 0);
    checkOutput("bp_i_valid", i_valid, 1);
    checkOutput("bp_head_cfg", i_cfg, 1);
    hold = i_dat;
    step();
    step();
    checkOutput("bp_i_dat_stable", i_dat, hold);
    applyStimulus(0, 0, 0);
    i_ready = 1'b1;
    #1;
    checkOutput("bp_t_ready_release", t_ready, 1);
    drain("bp_drain");
    checkOutput("bp_beat_cnt", beat_cnt, 16'(delivered));

    applyStimulus(1, 1, 1);
    step();
    applyStimulus(2, 0, 1);
    step();
    rst = 1'b1;
    applyStimulus(5, 1, 1);
    step();
    rst = 1'b0;
    applyStimulus(0, 0, 0);
    checkOutput("mrst_i_valid", i_valid, 0);
    checkOutput("mrst_beat_cnt", beat_cnt, 0);
    checkOutput("mrst_i_dat", i_dat, 0);
    checkOutput("mrst_t_ready", t_ready, 1);
    ghost = 0;
    for (int i = 0; i < 8; i++) begin
      if (i_valid) ghost++;
      step();
    end
    checkOutput("mrst_no_ghost", ghost, 0);

    for (int i = 0; i < 65537; i++) begin
      applyStimulus(L2'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1);
      step();
    end
    applyStimulus(0, 0, 0);
    drain("wrap_drain");
    checkOutput("wrap_delivered", delivered, 65537);
    checkOutput("wrap_beat_cnt", beat_cnt, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
